// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : game_pkg                                                   |
// | Description : Shared state encodings for the game-control FSM. The same  |
// |               3-bit codes are decoded by the video and game-logic blocks |
// |               from the dataout bus, so they must not be renumbered.      |
// | Contents    : state_t type, ST_* encodings, is_timed_state() helper.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_START    = 3'b000;
  localparam state_t ST_PLAYING  = 3'b001;
  localparam state_t ST_PAUSE    = 3'b010;
  localparam state_t ST_RESET    = 3'b011;
  localparam state_t ST_GAMEOVER = 3'b100;
  localparam state_t ST_RESPAWN  = 3'b101;

  // States whose dwell time is measured by the state timer.
  function automatic logic is_timed_state(input state_t s);
    return (s == ST_RESET) || (s == ST_RESPAWN) || (s == ST_GAMEOVER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rise_detect                                                |
// | Description : One-bit rising-edge detector. The previous-sample flop is  |
// |               updated every cycle so a level held high yields exactly    |
// |               one event; it clears on block reset so an input already    |
// |               high when reset releases produces an event.                |
// | Ports       : clk      in  - clock, rising edge                          |
// |               resetFSM in  - asynchronous active-high reset              |
// |               din      in  - level input                                 |
// |               rise     out - din & ~previous sample                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rise_detect (
  input  logic clk,
  input  logic resetFSM,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or posedge resetFSM) begin
    if (resetFSM) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : game_ctrl_fsm                                              |
// | Description : Game-control state machine: START / PLAYING / PAUSE /      |
// |               RESET / GAMEOVER / RESPAWN with a lives counter, a state   |
// |               timer for the timed states and edge-triggered buttons.     |
// | Ports       : clk         in  - clock, rising edge                       |
// |               resetFSM    in  - asynchronous active-high block reset     |
// |               reset       in  - synchronous game-restart request (level) |
// |               startGame   in  - start button, rising edge acts           |
// |               pauseGame   in  - pause button, rising edge acts           |
// |               dead        in  - player-death flag, rising edge acts      |
// |               dataout     out - current state code (game_pkg ST_*)       |
// |               lives       out - remaining lives                          |
// |               stateChange out - pulse: dataout changed at previous edge  |
// |               gameActive  out - high iff state is PLAYING                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int LIVES_W         = 2,
  parameter int RESPAWN_CYCLES  = 4,
  parameter int GAMEOVER_CYCLES = 8,
  parameter int RESET_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               resetFSM,
  input  logic               reset,
  input  logic               startGame,
  input  logic               pauseGame,
  input  logic               dead,
  output logic [2:0]         dataout,
  output logic [LIVES_W-1:0] lives,
  output logic               stateChange,
  output logic               gameActive
);

  localparam logic [LIVES_W-1:0] c_lives_init    = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] c_lives_one     = LIVES_W'(1);
  localparam logic [CNT_W-1:0]   c_reset_last    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_respawn_last  = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_gameover_last = CNT_W'(GAMEOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_timer_one     = CNT_W'(1);

  // --------------------------------------------------------------------
  // Button / event edge detection
  // --------------------------------------------------------------------
  logic w_start_rise;
  logic w_pause_rise;
  logic w_dead_rise;

  rise_detect u_start_rise (
    .clk      (clk),
    .resetFSM (resetFSM),
    .din      (startGame),
    .rise     (w_start_rise)
  );

  rise_detect u_pause_rise (
    .clk      (clk),
    .resetFSM (resetFSM),
    .din      (pauseGame),
    .rise     (w_pause_rise)
  );

  rise_detect u_dead_rise (
    .clk      (clk),
    .resetFSM (resetFSM),
    .din      (dead),
    .rise     (w_dead_rise)
  );

  // --------------------------------------------------------------------
  // State, lives, timer and registered status outputs
  // --------------------------------------------------------------------
  state_t             state_q,        state_d;
  logic [LIVES_W-1:0] lives_q,        lives_d;
  logic [CNT_W-1:0]   timer_q,        timer_d;
  logic               state_change_q, state_change_d;
  logic               game_active_q,  game_active_d;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;

    // A restart request overrides every other event, including any
    // button edge arriving in the same cycle (that edge is consumed).
    if (reset) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_START: begin
          if (w_start_rise) begin
            state_d = ST_PLAYING;
          end
        end
        ST_PLAYING: begin
          // Death outranks pause when both edges coincide.
          if (w_dead_rise) begin
            if (lives_q > c_lives_one) begin
              lives_d = lives_q - c_lives_one;
              state_d = ST_RESPAWN;
            end else begin
              // Covers lives==1 and the unreachable lives==0, so the
              // counter can never wrap below zero.
              lives_d = '0;
              state_d = ST_GAMEOVER;
            end
          end else if (w_pause_rise) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_pause_rise) begin
            state_d = ST_PLAYING;
          end
        end
        ST_RESET: begin
          if (timer_q >= c_reset_last) begin
            state_d = ST_START;
          end
        end
        ST_RESPAWN: begin
          if (timer_q == c_respawn_last) begin
            state_d = ST_PLAYING;
          end
        end
        ST_GAMEOVER: begin
          if (w_start_rise || (timer_q == c_gameover_last)) begin
            state_d = ST_START;
          end
        end
        default: begin
          // Unused encodings recover to a clean game start.
          state_d = ST_START;
        end
      endcase
    end

    // Lives are reloaded whenever the machine is (or lands) in START.
    if (state_d == ST_START) begin
      lives_d = c_lives_init;
    end

    // Timer measures dwell time in the current state; it restarts on
    // every transition and saturates rather than wrapping, which keeps a
    // long-held restart request from re-arming the RESET minimum.
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (is_timed_state(state_q) && (timer_q != '1)) begin
      timer_d = timer_q + c_timer_one;
    end

    state_change_d = (state_d != state_q);
    game_active_d  = (state_d == ST_PLAYING);
  end

  always_ff @(posedge clk or posedge resetFSM) begin
    if (resetFSM) begin
      state_q        <= ST_START;
      lives_q        <= c_lives_init;
      timer_q        <= '0;
      state_change_q <= 1'b0;
      game_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      timer_q        <= timer_d;
      state_change_q <= state_change_d;
      game_active_q  <= game_active_d;
    end
  end

  assign dataout     = state_q;
  assign lives       = lives_q;
  assign stateChange = state_change_q;
  assign gameActive  = game_active_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_game_ctrl_fsm                                           |
// | Description : Self-checking bench for game_ctrl_fsm. A behavioural model |
// |               tracks state, lives and dwell age from the game rules and  |
// |               is compared on every falling edge; directed literal        |
// |               expectations pin the model at key points.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_game_ctrl_fsm;

  localparam int LIVES           = 3;
  localparam int LIVES_W         = 2;
  localparam int RESPAWN_CYCLES  = 4;
  localparam int GAMEOVER_CYCLES = 8;
  localparam int RESET_CYCLES    = 2;
  localparam int CNT_W           = 8;

  localparam int S_START = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_RESET = 3;
  localparam int S_OVER  = 4;
  localparam int S_RESP  = 5;

  logic               clk       = 1'b0;
  logic               resetFSM  = 1'b1;
  logic               reset     = 1'b0;
  logic               startGame = 1'b0;
  logic               pauseGame = 1'b0;
  logic               dead      = 1'b0;
  logic [2:0]         dataout;
  logic [LIVES_W-1:0] lives;
  logic               stateChange;
  logic               gameActive;

  game_ctrl_fsm #(
    .LIVES           (LIVES),
    .LIVES_W         (LIVES_W),
    .RESPAWN_CYCLES  (RESPAWN_CYCLES),
    .GAMEOVER_CYCLES (GAMEOVER_CYCLES),
    .RESET_CYCLES    (RESET_CYCLES),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .resetFSM    (resetFSM),
    .reset       (reset),
    .startGame   (startGame),
    .pauseGame   (pauseGame),
    .dead        (dead),
    .dataout     (dataout),
    .lives       (lives),
    .stateChange (stateChange),
    .gameActive  (gameActive)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Behavioural model: state, lives, number of edges spent in state.
  // ------------------------------------------------------------------
  int m_state   = S_START;
  int m_lives   = LIVES;
  int m_age     = 0;
  bit m_changed = 1'b0;
  bit p_start   = 1'b0;
  bit p_pause   = 1'b0;
  bit p_dead    = 1'b0;

  always @(posedge clk or posedge resetFSM) begin
    if (resetFSM) begin
      m_state   = S_START;
      m_lives   = LIVES;
      m_age     = 0;
      m_changed = 1'b0;
      p_start   = 1'b0;
      p_pause   = 1'b0;
      p_dead    = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic model_step();
    bit rs;
    bit rp;
    bit rd;
    int nxt;
    rs = startGame && !p_start;
    rp = pauseGame && !p_pause;
    rd = dead && !p_dead;
    p_start = startGame;
    p_pause = pauseGame;
    p_dead  = dead;
    nxt = m_state;
    if (reset) begin
      nxt = S_RESET;
    end else begin
      case (m_state)
        S_START: if (rs) nxt = S_PLAY;
        S_PLAY: begin
          if (rd) begin
            if (m_lives > 1) begin
              m_lives = m_lives - 1;
              nxt = S_RESP;
            end else begin
              m_lives = 0;
              nxt = S_OVER;
            end
          end else if (rp) begin
            nxt = S_PAUSE;
          end
        end
        S_PAUSE: if (rp) nxt = S_PLAY;
        S_RESET: if (m_age + 1 >= RESET_CYCLES) nxt = S_START;
        S_RESP:  if (m_age + 1 == RESPAWN_CYCLES) nxt = S_PLAY;
        S_OVER:  if (rs || (m_age + 1 == GAMEOVER_CYCLES)) nxt = S_START;
        default: nxt = S_START;
      endcase
    end
    if (nxt == S_START) m_lives = LIVES;
    m_changed = (nxt != m_state);
    m_age     = m_changed ? 0 : m_age + 1;
    m_state   = nxt;
  endtask

  // ------------------------------------------------------------------
  // Compare process: model every cycle, plus directed literals.
  // ------------------------------------------------------------------
  int    checks = 0;
  int    errors = 0;
  bit    lit_en = 1'b0;
  string lit_name = "";
  int    lit_state = 0;
  int    lit_lives = 0;
  bit    lit_sc = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_state", {5'b0, dataout}, 8'(m_state));
    chk("model_lives", {6'b0, lives}, 8'(m_lives));
    chk("model_stateChange", {7'b0, stateChange}, {7'b0, m_changed});
    chk("model_gameActive", {7'b0, gameActive}, {7'b0, (m_state == S_PLAY)});
    if (lit_en) begin
      chk({lit_name, "_state"}, {5'b0, dataout}, 8'(lit_state));
      chk({lit_name, "_lives"}, {6'b0, lives}, 8'(lit_lives));
      chk({lit_name, "_stateChange"}, {7'b0, stateChange}, {7'b0, lit_sc});
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  // Expectation applied at the next falling edge.
  task automatic expect_next(input string n, input int st, input int lv, input bit sc);
    lit_name  = n;
    lit_state = st;
    lit_lives = lv;
    lit_sc    = sc;
    lit_en    = 1'b1;
  endtask

  task automatic lose_all();
    startGame = 1; tick(); startGame = 0; tick();
    repeat (2) begin
      dead = 1; tick(); dead = 0;
      repeat (5) tick();
    end
    dead = 1; tick(); dead = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset and start with startGame held 5 cycles
    tick(); tick();
    resetFSM = 0;
    expect_next("idle", S_START, 3, 0); tick();
    startGame = 1;
    expect_next("start", S_PLAY, 3, 1); tick();
    expect_next("start_hold", S_PLAY, 3, 0); tick();
    tick(); tick(); tick();
    startGame = 0; tick();

    // 2. Pause toggles: two pulses 3 cycles apart, then a held level
    pauseGame = 1; expect_next("pause1", S_PAUSE, 3, 1); tick();
    pauseGame = 0; tick(); tick();
    pauseGame = 1; expect_next("pause2", S_PLAY, 3, 1); tick();
    pauseGame = 0; tick();
    pauseGame = 1; expect_next("pause_held", S_PAUSE, 3, 1); tick();
    tick(); tick();
    expect_next("pause_held_once", S_PAUSE, 3, 0); tick();
    pauseGame = 0; tick();
    pauseGame = 1; expect_next("unpause", S_PLAY, 3, 1); tick();
    pauseGame = 0; tick();

    // 3. Deaths and respawn
    dead = 1; expect_next("death1", S_RESP, 2, 1); tick();
    dead = 0; tick();
    dead = 1; expect_next("resp_ignores_dead", S_RESP, 2, 0); tick();
    dead = 0; tick();
    expect_next("respawn1_done", S_PLAY, 2, 1); tick();
    dead = 1; expect_next("death2", S_RESP, 1, 1); tick();
    dead = 0; tick(); tick(); tick();
    expect_next("respawn2_done", S_PLAY, 1, 1); tick();
    dead = 1; expect_next("death3", S_OVER, 0, 1); tick();
    dead = 0;

    // 4. GAMEOVER timeout, then early exit via start
    repeat (6) tick();
    expect_next("over_last", S_OVER, 0, 0); tick();
    expect_next("over_timeout", S_START, 3, 1); tick();
    lose_all();
    tick();
    startGame = 1; expect_next("over_start", S_START, 3, 1); tick();
    startGame = 0; tick();

    // 5. Priority: dead over pause, reset over everything
    startGame = 1; tick(); startGame = 0; tick();
    dead = 1; pauseGame = 1;
    expect_next("dead_over_pause", S_RESP, 2, 1); tick();
    dead = 0; pauseGame = 0;
    repeat (5) tick();
    pauseGame = 1; expect_next("pause3", S_PAUSE, 2, 1); tick();
    pauseGame = 0; tick();
    reset = 1; expect_next("reset_enter", S_RESET, 2, 1); tick();
    reset = 0; expect_next("reset_min", S_RESET, 2, 0); tick();
    expect_next("reset_exit", S_START, 3, 1); tick();
    reset = 1; startGame = 1;
    expect_next("reset_beats_start", S_RESET, 3, 1); tick();
    reset = 0; tick(); tick();
    expect_next("start_lost", S_START, 3, 0); tick();
    startGame = 0; tick();

    // 6. Asynchronous block reset mid-RESPAWN with start held
    startGame = 1; tick(); startGame = 0; tick();
    dead = 1; tick(); dead = 0;
    @(posedge clk);
    #2;
    resetFSM = 1; startGame = 1;
    expect_next("async_reset", S_START, 3, 0);
    tick(); tick();
    resetFSM = 0;
    expect_next("held_start_after_reset", S_PLAY, 3, 1); tick();
    startGame = 0; tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Parametrised game-control state machine: next generation of the console's game FSM. Tracks START/PLAYING/PAUSE/RESET/GAMEOVER, and adds:
- a lives counter with a timed RESPAWN state,
- edge-triggered button handling (pause toggles),
- timed RESET and GAMEOVER states.

It sits between the button/collision logic and the video/game-logic blocks, which consume `dataout`, `lives` and `stateChange`.

## Interface
- `LIVES`, 3 — lives loaded on entry to START; range 1..2^LIVES_W-1
- `LIVES_W`, 2 — width of `lives`
- `RESPAWN_CYCLES`, 4 — cycles spent in RESPAWN; ≥1
- `GAMEOVER_CYCLES`, 8 — cycles in GAMEOVER before automatic return to START; ≥1
- `RESET_CYCLES`, 2 — minimum cycles spent in RESET; ≥1
- `CNT_W`, 8 — state-timer width; must hold max(*_CYCLES)-1

Ports:
- `clk` in 1 — clock, rising edge
- `resetFSM` in 1 — asynchronous, active-high block reset
- `reset` in 1 — game-restart request; level-sensitive, synchronous
- `startGame` in 1 — start button; rising edge acts
- `pauseGame` in 1 — pause button; rising edge acts
- `dead` in 1 — player-death flag; rising edge acts
- `dataout` out 3 — current state: START 000, PLAYING 001, PAUSE 010, RESET 011, GAMEOVER 100, RESPAWN 101
- `lives` out LIVES_W — remaining lives
- `stateChange` out 1 — one-cycle pulse when `dataout` changed at the previous edge
- `gameActive` out 1 — high iff state is PLAYING

## Operation
- **Edge detection:** a rise event is defined as `in & ~prev`. `prev` is registered every cycle in all states and reset to 0, so a level held high produces exactly one event.
- **`resetFSM` values:** state START, `lives`=LIVES, timer 0, all `prev` 0, `stateChange` 0, `gameActive` 0.
- **`reset`=1 in any state:** next state is RESET. This has highest priority over every other event.
- **RESET:** timer counts and saturates.
  - Exit to START when `reset`=0 and timer ≥ RESET_CYCLES-1.
  - Holding `reset` keeps the FSM in RESET.
- **START:** `lives` reloaded to LIVES; start rise → PLAYING. `pauseGame` and `dead` are ignored.
- **PLAYING:** `dead` has priority over `pauseGame` when both rise in the same cycle.
  - Dead rise with `lives`>1: `lives`-1, → RESPAWN.
  - Dead rise with `lives`==1: `lives`=0, → GAMEOVER.
  - Pause rise (no dead rise): → PAUSE.
  - Start rise is ignored.
- **PAUSE:** pause rise → PLAYING. Start and dead rises are ignored; they are not queued.
- **RESPAWN:** → PLAYING after exactly RESPAWN_CYCLES cycles. All button and dead events are ignored.
- **GAMEOVER:** start rise → START immediately; otherwise → START when timer == GAMEOVER_CYCLES-1.
- **Timer:** cleared on every state change, increments each cycle while in RESET, RESPAWN or GAMEOVER.
- **`lives` arithmetic:** never wraps; it can only decrement from ≥1.

## Timing
- All outputs are registered; no combinational input-to-output path.
- An input first sampled high at edge N (low at N-1) updates `dataout` at edge N, i.e. 1-cycle latency.
  - `stateChange` is high during the cycle following edge N.
  - `gameActive` tracks `dataout` in the same cycle.
- RESPAWN entered at edge N: `dataout`=101 for RESPAWN_CYCLES cycles, and 001 after edge N+RESPAWN_CYCLES.
- RESET with `reset` pulsed for 1 cycle at edge N: RESET lasts RESET_CYCLES cycles.
- `resetFSM` asserted mid-operation forces reset values asynchronously. The first edge after deassertion evaluates from START with `prev`=0, so a button already held high produces an event.
- `reset` and `startGame` rising together: RESET wins and the start event is lost.

## Structure
- Package `game_pkg`: the 3-bit state encodings (`ST_START`..`ST_RESPAWN`) and the state type. The same encodings are used by the video/game-logic consumers.
- Sub-module `rise_detect`: 1-bit register plus AND. It uses `clk` and async `resetFSM` and is instantiated for `startGame`, `pauseGame` and `dead`.
- The FSM, timer and lives counter stay in `game_ctrl_fsm`.

## Test plan
1. **Reset and start:** `resetFSM` pulse, then `startGame` held high for 5 cycles → `dataout` 000, `lives`=3, then 001 one cycle after first sample; `stateChange` pulses exactly once.
2. **Pause toggle:** in PLAYING, two 1-cycle pause pulses 3 cycles apart → 010 then 001. Pause held high 4 cycles → only one toggle.
3. **Death and respawn:** three dead rises with default parameters.
   - First two: `lives` 3→2→1, each followed by exactly 4 cycles of 101, then 001.
   - Third: `lives`=0, 100; dead rises during RESPAWN have no effect.
4. **GAMEOVER exit:** with no start pulse → 000 after 8 cycles, `lives`=3. Repeat with a start pulse at cycle 2 → 000 next cycle.
5. **Priority:** dead and pause rise together in PLAYING → 101. `reset` high in PAUSE → 011, lasting 2 cycles after `reset` falls.
6. **Async reset:** `resetFSM` asserted mid-RESPAWN between clock edges → `dataout`=000 and `lives`=3 before the next edge.
